// File: rtl/data_mem_ctrl.sv
// Data-port memory controller: decodes CPU accesses into word RAM, a peripheral
// window or unmapped space, with byte/half/word lanes and a req/ack handshake.
module data_mem_ctrl #(
  parameter int          RAM_AW         = 8,
  parameter int          READ_LATENCY   = 1,
  parameter logic [19:0] PERIPH_BASE    = 20'h40000,
  parameter int          PERIPH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] last_err_addr,
  output logic        periph_read,
  output logic        periph_write,
  output logic [31:0] periph_addr,
  output logic [31:0] periph_wdata,
  input  logic [31:0] periph_rdata,
  input  logic        periph_ack
);

  typedef enum logic [1:0] {IDLE, RAM_RD, PER_WAIT, RESP} state_t;

  localparam logic [2:0] LAT_LOAD = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;
  localparam logic [7:0] TO_LOAD  = 8'(PERIPH_TIMEOUT - 1);

  state_t            state;
  logic [2:0]        lat_cnt;
  logic [7:0]        to_cnt;
  logic [RAM_AW-1:0] cap_word;
  logic [1:0]        cap_lane;
  logic [1:0]        cap_size;
  logic              cap_sign;

  logic [31:0] mem [0:2**RAM_AW-1];

  logic        req_any, ram_hit, per_hit, misalign, fault, ram_we;
  logic [3:0]  be;
  logic [31:0] wrep;

  assign ready    = (state == IDLE);
  assign req_any  = req_read | req_write;
  assign ram_hit  = (addr[31:RAM_AW+2] == '0);
  assign per_hit  = (addr[31:12] == PERIPH_BASE);
  assign misalign = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign fault    = (req_read & req_write) | (size == 2'b11) | misalign |
                    (per_hit & ~ram_hit & (size != 2'b10)) | (~ram_hit & ~per_hit);
  assign ram_we   = ready & req_write & ~fault & ram_hit;

  always_comb begin
    be   = 4'b1111;
    wrep = wdata;
    case (size)
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        wrep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << {addr[1], 1'b0};
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr[RAM_AW+1:2]][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic sx);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (sz)
      2'b00:   extract = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   extract = {{16{sx & sh[15]}}, sh[15:0]};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ack           <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      last_err_addr <= '0;
      periph_read   <= 1'b0;
      periph_write  <= 1'b0;
      periph_addr   <= '0;
      periph_wdata  <= '0;
      lat_cnt       <= '0;
      to_cnt        <= '0;
      cap_word      <= '0;
      cap_lane      <= '0;
      cap_size      <= '0;
      cap_sign      <= 1'b0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            cap_word <= addr[RAM_AW+1:2];
            cap_lane <= addr[1:0];
            cap_size <= size;
            cap_sign <= sign_ext;
            if (fault) begin
              state         <= RESP;
              ack           <= 1'b1;
              err           <= 1'b1;
              last_err_addr <= addr;
            end else if (ram_hit) begin
              if (req_write) begin
                state <= RESP;
                ack   <= 1'b1;
              end else if (READ_LATENCY == 1) begin
                state <= RESP;
                ack   <= 1'b1;
                rdata <= extract(mem[addr[RAM_AW+1:2]], size, addr[1:0], sign_ext);
              end else begin
                state   <= RAM_RD;
                lat_cnt <= LAT_LOAD;
              end
            end else begin
              state        <= PER_WAIT;
              periph_read  <= req_read;
              periph_write <= req_write;
              periph_addr  <= addr;
              periph_wdata <= wdata;
              to_cnt       <= TO_LOAD;
            end
          end
        end
        RAM_RD: begin
          if (lat_cnt == 3'd0) begin
            state <= RESP;
            ack   <= 1'b1;
            rdata <= extract(mem[cap_word], cap_size, cap_lane, cap_sign);
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        PER_WAIT: begin
          // A peripheral ack on the final timeout cycle still counts as success.
          if (periph_ack) begin
            periph_read  <= 1'b0;
            periph_write <= 1'b0;
            state        <= RESP;
            ack          <= 1'b1;
            if (periph_read) rdata <= periph_rdata;
          end else if (to_cnt == 8'd0) begin
            periph_read   <= 1'b0;
            periph_write  <= 1'b0;
            state         <= RESP;
            ack           <= 1'b1;
            err           <= 1'b1;
            last_err_addr <= periph_addr;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed test-plan cases, then random accesses
// checked against a byte-array memory and peripheral model.
module tb_data_mem_ctrl;
  localparam int RAM_AW = 8;
  localparam int RLAT   = 2;
  localparam int TO     = 15;

  logic        clk = 1'b0;
  logic        reset, req_read, req_write, sign_ext, periph_ack;
  logic [31:0] addr, wdata, periph_rdata;
  logic [1:0]  size;
  logic        ready, ack, err, periph_read, periph_write;
  logic [31:0] rdata, last_err_addr, periph_addr, periph_wdata;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mm [0:1023];
  logic [31:0] exp_last;
  logic [31:0] got;

  always #5 clk = ~clk;

  data_mem_ctrl #(.RAM_AW(RAM_AW), .READ_LATENCY(RLAT), .PERIPH_BASE(20'h40000),
                  .PERIPH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .addr(addr), .size(size), .sign_ext(sign_ext), .wdata(wdata),
    .ready(ready), .ack(ack), .err(err), .rdata(rdata), .last_err_addr(last_err_addr),
    .periph_read(periph_read), .periph_write(periph_write), .periph_addr(periph_addr),
    .periph_wdata(periph_wdata), .periph_rdata(periph_rdata), .periph_ack(periph_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; called #1 after a rising edge with the controller idle.
  // pdelay = number of strobe cycles before the peripheral acks (0 = never).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic sx, input logic [31:0] wd,
                        input int pdelay, input logic [31:0] prd, output logic [31:0] res);
    int k, strobes, nbytes, exp_lat, exp_strobes;
    logic exp_err, is_ram, is_per, got_ack;
    logic [31:0] exp_rd;
    is_ram = ((a >> (RAM_AW + 2)) == 0);
    is_per = (a[31:12] == 20'h40000);
    nbytes = (sz == 2'd3) ? 4 : (1 << sz);
    exp_err = (rd && wr) || (sz == 2'd3) || ((a % nbytes) != 0) ||
              (is_per && sz != 2'd2) || (!is_ram && !is_per);
    exp_rd = 0;
    exp_strobes = 0;
    exp_lat = 1;
    if (exp_err) begin
      exp_last = a;
    end else if (is_ram && wr) begin
      for (int i = 0; i < nbytes; i++) mm[a[9:0] + i] = wd[8*i +: 8];
    end else if (is_ram) begin
      exp_lat = RLAT;
      for (int i = 0; i < nbytes; i++) exp_rd = exp_rd | (32'(mm[a[9:0] + i]) << (8*i));
      if (sx && nbytes < 4 && exp_rd[8*nbytes-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*nbytes));
    end else if (pdelay > 0 && pdelay <= TO) begin
      exp_lat = pdelay + 1;
      exp_strobes = pdelay;
      exp_rd = rd ? prd : 32'h0;
    end else begin
      exp_lat = TO + 1;
      exp_strobes = TO;
      exp_err = 1'b1;
      exp_last = a;
    end

    req_read = rd; req_write = wr; addr = a; size = sz; sign_ext = sx; wdata = wd;
    k = 0; strobes = 0; got_ack = 1'b0;
    while (k < 40 && !got_ack) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk("busy_after_accept", ready, 1'b0);
      periph_ack = 1'b0;
      periph_rdata = $urandom;
      if (periph_read || periph_write) begin
        strobes++;
        if (strobes == 1) begin
          chk("per_addr", periph_addr, a);
          chk("per_dir", {periph_read, periph_write}, {rd, wr});
          if (wr) chk("per_wdata", periph_wdata, wd);
        end
        if (pdelay > 0 && strobes == pdelay) begin
          periph_ack = 1'b1;
          periph_rdata = prd;
        end
      end
      if (ack) got_ack = 1'b1;
    end
    req_read = 1'b0; req_write = 1'b0; periph_ack = 1'b0;
    res = rdata;
    chk("ack_seen", got_ack, 1'b1);
    chk("ack_latency", k, exp_lat);
    chk("err", err, exp_err);
    chk("rdata", rdata, exp_rd);
    chk("last_err_addr", last_err_addr, exp_last);
    chk("strobe_cycles", strobes, exp_strobes);
    @(posedge clk); #1;
    chk("ready_after", ready, 1'b1);
    chk("ack_pulse", ack, 1'b0);
    chk("idle_rdata", rdata, 32'h0);
    chk("idle_err", err, 1'b0);
  endtask

  initial begin
    logic [31:0] a, w;
    logic [1:0]  sz;
    int          kind, pd;
    reset = 1'b1; req_read = 0; req_write = 0; addr = 0; size = 0; sign_ext = 0;
    wdata = 0; periph_ack = 0; periph_rdata = 0; exp_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_last_err", last_err_addr, 32'h0);
    chk("rst_strobes", {periph_read, periph_write}, 2'b00);
    chk("rst_paddr", periph_addr, 32'h0);
    chk("rst_pwdata", periph_wdata, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) access(0, 1, 32'(i * 4), 2'd2, 0, $urandom, 0, 0, got);

    access(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, 0, got);
    access(1, 0, 32'h10, 2'd2, 0, 0, 0, 0, got);
    chk("word_read", got, 32'hDEADBEEF);
    access(0, 1, 32'h10, 2'd2, 0, 32'h11223344, 0, 0, got);
    access(0, 1, 32'h13, 2'd0, 0, 32'h00000080, 0, 0, got);
    access(1, 0, 32'h10, 2'd2, 0, 0, 0, 0, got);
    chk("byte_lane_word", got, 32'h80223344);
    access(1, 0, 32'h13, 2'd0, 1, 0, 0, 0, got);
    chk("signed_byte", got, 32'hFFFFFF80);
    access(1, 0, 32'h12, 2'd1, 0, 0, 0, 0, got);
    chk("unsigned_half", got, 32'h00008022);

    access(1, 0, 32'h2, 2'd2, 0, 0, 0, 0, got);
    chk("misalign_last", last_err_addr, 32'h2);
    access(0, 1, 32'h2, 2'd2, 0, 32'hCAFEF00D, 0, 0, got);
    access(1, 0, 32'h0, 2'd2, 0, 0, 0, 0, got);
    access(1, 0, 32'h1000_0000, 2'd2, 0, 0, 0, 0, got);
    access(1, 1, 32'h20, 2'd2, 0, 32'h55, 0, 0, got);
    access(1, 0, 32'h20, 2'd2, 0, 0, 0, 0, got);

    access(1, 0, 32'h4000_0014, 2'd2, 0, 0, 3, 32'h5A, got);
    chk("per_rdata", got, 32'h5A);
    access(0, 1, 32'h4000_000C, 2'd2, 0, 32'h0BADF00D, 0, 0, got);
    chk("timeout_last", last_err_addr, 32'h4000_000C);

    req_write = 1; addr = 32'h4000_0008; size = 2'd2; wdata = 32'h12345678; sign_ext = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_strobe", periph_write, 1'b1);
    req_write = 0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_last", last_err_addr, 32'h0);
    chk("mid_rst_pwrite", periph_write, 1'b0);
    chk("mid_rst_pread", periph_read, 1'b0);
    chk("mid_rst_paddr", periph_addr, 32'h0);
    chk("mid_rst_pwdata", periph_wdata, 32'h0);
    exp_last = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_pwrite", periph_write, 1'b0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      w  = $urandom;
      pd = 0;
      if (kind <= 6) a = 32'($urandom_range(0, 63));
      else if (kind == 7) begin
        a = {20'h40000, 10'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
        if ($urandom_range(0, 2) != 0) sz = 2'd2;
        pd = $urandom_range(0, 20);
      end else a = $urandom | 32'h0001_0000;
      if (kind == 9) access(1, 1, a, sz, 1'($urandom), w, pd, $urandom, got);
      else if ($urandom_range(0, 1) == 1) access(1, 0, a, sz, 1'($urandom), w, pd, $urandom, got);
      else access(0, 1, a, sz, 1'($urandom), w, pd, $urandom, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory controller for the MIPS CPU data port. It decodes each CPU request into a word-addressed RAM, a peripheral window, or unmapped space, and supports byte, halfword and word access with byte-lane writes and sign/zero-extended reads. Completion uses a request/acknowledge handshake with configurable RAM read latency and a peripheral timeout. Errors are reported per access, and the address of the most recent faulting access is latched.

## Interface
- RAM_AW, 8: RAM word-address width; depth is 2**RAM_AW words.
- READ_LATENCY, 1: cycles from request acceptance to read ack for RAM; legal range 1..4.
- PERIPH_BASE, 20'h40000: value of addr[31:12] that selects the peripheral window.
- PERIPH_TIMEOUT, 15: maximum cycles to wait for periph_ack; legal range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  1  read request.
- req_write  in  1  write request.
- addr  in  32  byte address.
- size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- sign_ext  in  1  sign-extend sub-word read data (1) or zero-extend (0).
- wdata  in  32  write data, right-aligned for sub-word accesses.
- ready  out  1  controller idle; a request is accepted on an edge where ready=1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; the access faulted.
- rdata  out  32  read data, valid with ack on a successful read, otherwise 0.
- last_err_addr  out  32  addr of the most recent faulting access.
- periph_read, periph_write  out  1  peripheral strobes, held until periph_ack or timeout.
- periph_addr  out  32  captured address.
- periph_wdata  out  32  captured write data.
- periph_rdata  in  32  peripheral read data, sampled with periph_ack.
- periph_ack  in  1  peripheral completion.

## Operation
- **States:** IDLE, RAM_RD, PER_WAIT, RESP.
- **ready:** ready=1 only in IDLE.
- **Acceptance:** a request is accepted in IDLE when req_read or req_write is 1. addr, size, sign_ext and wdata are captured at that edge.
- **Error classification** (evaluated at acceptance, in priority order):
  - req_read and req_write both 1.
  - size=11.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - Sub-word access to the peripheral window.
  - Unmapped address: neither RAM (addr[31:RAM_AW+2]==0) nor peripheral (addr[31:12]==PERIPH_BASE).
  - On any of these: go to RESP with err=1, perform no RAM write and no peripheral strobe, and latch last_err_addr.
- **RAM write:** written at the acceptance edge, using byte enables derived from size and addr[1:0] (little-endian lanes; wdata byte/half replicated onto the selected lane). Then RESP.
- **RAM read:** go to RAM_RD. A counter runs READ_LATENCY-1 cycles, then ack. The selected lane is shifted down and extended per sign_ext.
- **Peripheral access:** go to PER_WAIT, asserting periph_read or periph_write from the next cycle with the captured addr/wdata.
  - periph_ack sampled 1: drop the strobe; ack=1, err=0 on the following cycle; rdata = periph_rdata for reads.
  - PERIPH_TIMEOUT cycles without periph_ack: drop the strobe; ack=1 with err=1; latch last_err_addr.
- **RESP:** ack is pulsed for one cycle, then return to IDLE.
- **Requests while not ready:** ignored; the CPU must hold its request.
- **RAM and reset:** RAM contents are not cleared by reset and are undefined until written.
- **Reset** (asynchronous, including mid-operation):
  - state=IDLE, so ready=1.
  - ack=0, err=0, rdata=0.
  - last_err_addr=0.
  - periph_read=0, periph_write=0, periph_addr=0, periph_wdata=0.
  - latency and timeout counters=0.
  - Any pending access is abandoned.

## Timing
- Accepted on edge T:
  - Write / error ack: high during cycle T+1.
  - RAM read ack: high during cycle T+READ_LATENCY.
- Peripheral strobe: high from T+1.
  - periph_ack sampled at edge P → ack during the cycle after P.
  - Timeout → ack during T+PERIPH_TIMEOUT+1.
- ready returns to 1 in the cycle after ack. Minimum request spacing is 2 cycles.
- Outside ack cycles: rdata=0, err=0.

## Test plan
- **Reset:** reset pulse mid-PER_WAIT → all outputs at reset values immediately; ready=1 next cycle; periph_write=0.
- **Word write/read:** write 0xDEADBEEF to 0x0000_0010, then read it with READ_LATENCY=2 → ack one cycle after the write; read ack 2 cycles after acceptance; rdata=0xDEADBEEF, err=0.
- **Sub-word lanes:**
  - Byte write 0x80 to 0x13 over 0x11223344 → word reads 0x80223344.
  - Signed byte read of 0x13 → 0xFFFFFF80.
  - Unsigned half read of 0x12 → 0x00008022.
- **Faults:**
  - Word read at 0x0000_0002 → ack+err in T+1; last_err_addr=0x00000002; RAM unchanged.
  - Read of 0x1000_0000 (unmapped) → err.
  - Both req_read and req_write high → err.
- **Peripheral ok:** read 0x4000_0014 with periph_ack after 3 cycles and periph_rdata=0x5A → periph_read high 3 cycles; ack next cycle with rdata=0x5A.
- **Peripheral timeout:** write 0x4000_000C with no periph_ack, PERIPH_TIMEOUT=15 → strobe drops; ack+err at T+16; last_err_addr=0x4000000C.
